// File: rtl/panel_scanner_pkg.sv
// rtl/panel_scanner_pkg.sv - shared geometry, state encoding and pixel field helpers for the panel scanner
package panel_scanner_pkg;
    localparam int COLS      = 32;
    localparam int ROWS      = 16;
    localparam int SCAN_ROWS = 8;
    localparam int ADDR_W    = $clog2(ROWS) + $clog2(COLS);
    localparam int ROW_W     = $clog2(SCAN_ROWS);

    localparam int CH_W  = 8;
    localparam int PIX_W = 3 * CH_W;
    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

    typedef enum logic [2:0] {RD_TOP, RD_BOT, SETUP, CLK, LATCH, SHOW} scan_state_e;

    // Picks one bit position out of each colour channel, returned as {R,G,B}.
    function automatic logic [2:0] plane_rgb(input logic [PIX_W-1:0] pix, input int unsigned bit_idx);
        return {pix[R_LSB+bit_idx], pix[G_LSB+bit_idx], pix[B_LSB+bit_idx]};
    endfunction
endpackage

// File: rtl/panel_scanner_if.sv
// rtl/panel_scanner_if.sv - framebuffer read port and HUB75 panel pins
interface panel_scanner_if;
    import panel_scanner_pkg::*;

    logic [ADDR_W-1:0] rd_addr;
    logic              rd_buf;
    logic [PIX_W-1:0]  rd_data;
    logic [2:0]        rgb1;
    logic [2:0]        rgb2;
    logic [ROW_W-1:0]  row_addr;
    logic              sclk;
    logic              lat;
    logic              oe_n;

    modport master (
        output rd_addr, rd_buf, rgb1, rgb2, row_addr, sclk, lat, oe_n,
        input  rd_data
    );

    modport slave (
        input  rd_addr, rd_buf, rgb1, rgb2, row_addr, sclk, lat, oe_n,
        output rd_data
    );
endinterface

// File: rtl/panel_scanner_bcm_timer.sv
// rtl/panel_scanner_bcm_timer.sv - per-plane display-time counter for binary-coded modulation
module bcm_timer #(
    parameter int BITS = 4,
    parameter int BASE = 8,
    parameter int PW   = (BITS > 1) ? $clog2(BITS) : 1,
    parameter int CW   = $clog2((BASE << (BITS - 1)) + 1)
) (
    input  logic          pixclk,
    input  logic          reset,
    input  logic          load,
    input  logic [PW-1:0] plane,
    output logic          done
);
    logic [CW-1:0] cnt_q, cnt_d;

    // Loaded during LATCH, so the first SHOW cycle already holds the full count.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(BASE << plane);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == CW'(1));
endmodule

// File: rtl/panel_scanner.sv
// rtl/panel_scanner.sv - 1/8-scan HUB75 driver reading the double-buffered framebuffer with BCM brightness
module panel_scanner
    import panel_scanner_pkg::*;
#(
    parameter int COLS = 32,
    parameter int BITS = 4,
    parameter int BASE = 8
) (
    input  logic pixclk,
    input  logic reset,
    input  logic display,
    output logic frame_start,
    panel_scanner_if.master pif
);
    localparam int PW      = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int PLANE_0 = CH_W - BITS;

    scan_state_e      state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [PW-1:0]    plane_q, plane_d;
    logic [4:0]       col_q, col_d;
    logic [PIX_W-1:0] top_q, top_d;
    logic             rd_buf_q, rd_buf_d;
    logic [2:0]       rgb1_q, rgb1_d, rgb2_q, rgb2_d;
    logic [ROW_W-1:0] row_addr_q, row_addr_d;
    logic             sclk_q, sclk_d, lat_q, lat_d, oe_n_q, oe_n_d;

    logic       rd_buf_now;
    logic [2:0] setup_rgb1, setup_rgb2;
    logic       show_done;

    bcm_timer #(.BITS(BITS), .BASE(BASE), .PW(PW)) u_bcm_timer (
        .pixclk (pixclk),
        .reset  (reset),
        .load   (state_q == LATCH),
        .plane  (plane_q),
        .done   (show_done)
    );

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        plane_d    = plane_q;
        col_d      = col_q;
        top_d      = top_q;
        rgb1_d     = rgb1_q;
        rgb2_d     = rgb2_q;
        row_addr_d = row_addr_q;

        // The new buffer select must already steer the very first read of the frame.
        frame_start = (state_q == RD_TOP) && (row_q == '0) && (plane_q == '0) && (col_q == '0) && !reset;
        rd_buf_now  = frame_start ? display : rd_buf_q;
        rd_buf_d    = rd_buf_now;

        setup_rgb1 = plane_rgb(top_q, PLANE_0 + int'(plane_q));
        setup_rgb2 = plane_rgb(pif.rd_data, PLANE_0 + int'(plane_q));

        case (state_q)
            RD_TOP: state_d = RD_BOT;
            RD_BOT: begin
                top_d   = pif.rd_data;
                state_d = SETUP;
            end
            SETUP: begin
                rgb1_d  = setup_rgb1;
                rgb2_d  = setup_rgb2;
                state_d = CLK;
            end
            CLK: begin
                col_d = col_q + 5'd1;
                if (col_q == 5'(COLS - 1)) begin
                    state_d    = LATCH;
                    row_addr_d = row_q;
                end else begin
                    state_d = RD_TOP;
                end
            end
            LATCH: state_d = SHOW;
            SHOW: begin
                if (show_done) begin
                    state_d = RD_TOP;
                    if (plane_q == PW'(BITS - 1)) begin
                        plane_d = '0;
                        row_d   = row_q + ROW_W'(1);
                    end else begin
                        plane_d = plane_q + PW'(1);
                    end
                end
            end
            default: state_d = RD_TOP;
        endcase

        sclk_d = (state_d == CLK);
        lat_d  = (state_d == LATCH);
        oe_n_d = (state_d != SHOW);
    end

    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            state_q    <= RD_TOP;
            row_q      <= '0;
            plane_q    <= '0;
            col_q      <= '0;
            top_q      <= '0;
            rd_buf_q   <= 1'b0;
            rgb1_q     <= '0;
            rgb2_q     <= '0;
            row_addr_q <= '0;
            sclk_q     <= 1'b0;
            lat_q      <= 1'b0;
            oe_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            plane_q    <= plane_d;
            col_q      <= col_d;
            top_q      <= top_d;
            rd_buf_q   <= rd_buf_d;
            rgb1_q     <= rgb1_d;
            rgb2_q     <= rgb2_d;
            row_addr_q <= row_addr_d;
            sclk_q     <= sclk_d;
            lat_q      <= lat_d;
            oe_n_q     <= oe_n_d;
        end
    end

    assign pif.rd_addr  = {state_q == RD_BOT, row_q, col_q};
    assign pif.rd_buf   = rd_buf_now;
    assign pif.rgb1     = (state_q == SETUP) ? setup_rgb1 : rgb1_q;
    assign pif.rgb2     = (state_q == SETUP) ? setup_rgb2 : rgb2_q;
    assign pif.row_addr = row_addr_q;
    assign pif.sclk     = sclk_q;
    assign pif.lat      = lat_q;
    assign pif.oe_n     = oe_n_q;
endmodule

// File: tb/tb_panel_scanner.sv
// tb/tb_panel_scanner.sv - self-checking bench for panel_scanner with a model framebuffer RAM
module tb_panel_scanner;
    localparam int BITS  = 4;
    localparam int BASE  = 8;
    localparam int FRAME = 5088;

    logic pixclk = 1'b0;
    logic reset = 1'b1;
    logic display = 1'b0;
    logic frame_start;

    panel_scanner_if pif();

    panel_scanner #(.COLS(32), .BITS(BITS), .BASE(BASE)) dut (
        .pixclk      (pixclk),
        .reset       (reset),
        .display     (display),
        .frame_start (frame_start),
        .pif         (pif)
    );

    always #5 pixclk = ~pixclk;

    logic [23:0] mem [0:1023];
    always @(posedge pixclk) pif.rd_data <= mem[{pif.rd_buf, pif.rd_addr}];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  row;
        logic [4:0]  col;
        logic [23:0] pix;
        logic [23:0] fill;
        logic [11:0] exp_pix;
        logic [11:0] exp_fill;
    } vec_t;

    typedef struct {
        logic [2:0] r1;
        logic [2:0] r2;
    } sb_t;

    vec_t vecs[5];
    sb_t  sb_q[$];

    task automatic load_image(input vec_t v);
        for (int a = 0; a < 1024; a++) mem[a] = v.fill;
        mem[{1'b0, v.row, v.col}] = v.pix;
        mem[{1'b1, v.row, v.col}] = v.pix;
    endtask

    task automatic push_sb(input vec_t v, input int n);
        sb_t e;
        for (int i = 0; i < n; i++) begin
            int r, p, c;
            r = (i / 128) % 8;
            p = (i / 32) % 4;
            c = i % 32;
            e.r1 = (int'(v.row) == r && int'(v.col) == c) ? v.exp_pix[p*3 +: 3] : v.exp_fill[p*3 +: 3];
            e.r2 = (int'(v.row) == r + 8 && int'(v.col) == c) ? v.exp_pix[p*3 +: 3] : v.exp_fill[p*3 +: 3];
            sb_q.push_back(e);
        end
    endtask

    task automatic run_frame(input bit timing, input int toggle_at);
        int lat_cnt, first_lat, run, viol, fs_cnt;
        int runs[$];
        logic [2:0] prev_row;
        sb_t e;
        lat_cnt = 0; first_lat = -1; run = 0; viol = 0; fs_cnt = 0; prev_row = 3'd0;
        reset = 1'b1;
        repeat (2) @(posedge pixclk);
        #1 reset = 1'b0;
        for (int cyc = 0; cyc <= FRAME + 128; cyc++) begin
            @(negedge pixclk);
            if (cyc == toggle_at) display = 1'b1;
            if (frame_start) fs_cnt++;
            if (cyc == 0 || cyc == FRAME) check("frame_start_pulse", frame_start, 1);
            if (timing && cyc == 0) check("rd_buf_first", pif.rd_buf, 0);
            if (toggle_at >= 0 && (cyc == toggle_at + 1 || cyc == FRAME - 1)) check("rd_buf_hold", pif.rd_buf, 0);
            if (toggle_at >= 0 && cyc == FRAME) check("rd_buf_switch", pif.rd_buf, 1);
            if (pif.sclk) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("rgb1", pif.rgb1, e.r1);
                    check("rgb2", pif.rgb2, e.r2);
                end
            end
            if (pif.lat) begin
                lat_cnt++;
                if (lat_cnt == 1) first_lat = cyc;
                if (timing && lat_cnt <= 32) check("row_addr_seq", pif.row_addr, (lat_cnt - 1) / 4);
                if (timing && lat_cnt == 33) check("row_addr_wrap", pif.row_addr, 0);
            end
            if (pif.row_addr !== prev_row && !pif.oe_n) viol++;
            prev_row = pif.row_addr;
            if (!pif.oe_n) run++;
            else if (run > 0) begin
                runs.push_back(run);
                run = 0;
            end
        end
        check("sb_drained", sb_q.size(), 0);
        if (timing) begin
            check("first_lat_cycle", first_lat, 128);
            check("lat_count", lat_cnt, 33);
            check("frame_start_count", fs_cnt, 2);
            check("row_change_while_lit", viol, 0);
            check("show_run_count", runs.size(), 32);
            for (int i = 0; i < runs.size() && i < 32; i++)
                check("show_len", runs[i], BASE << (i % 4));
        end
    endtask

    initial begin
        bit found;
        vecs[0] = '{row: 4'd0,  col: 5'd0,  pix: 24'hFFFFFF, fill: 24'hFFFFFF, exp_pix: 12'hFFF, exp_fill: 12'hFFF};
        vecs[1] = '{row: 4'd9,  col: 5'd5,  pix: 24'h800000, fill: 24'h000000, exp_pix: 12'b100_000_000_000, exp_fill: 12'h000};
        vecs[2] = '{row: 4'd0,  col: 5'd0,  pix: 24'h102040, fill: 24'h000000, exp_pix: 12'b000_001_010_100, exp_fill: 12'h000};
        vecs[3] = '{row: 4'd7,  col: 5'd16, pix: 24'h0F0F0F, fill: 24'h000000, exp_pix: 12'h000, exp_fill: 12'h000};
        vecs[4] = '{row: 4'd15, col: 5'd31, pix: 24'h00F000, fill: 24'h000000, exp_pix: 12'b010_010_010_010, exp_fill: 12'h000};

        repeat (3) @(posedge pixclk);
        @(negedge pixclk);
        check("rst_oe_n", pif.oe_n, 1);
        check("rst_lat", pif.lat, 0);
        check("rst_sclk", pif.sclk, 0);
        check("rst_row_addr", pif.row_addr, 0);
        check("rst_rd_addr", pif.rd_addr, 0);
        check("rst_rd_buf", pif.rd_buf, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_rgb", {pif.rgb1, pif.rgb2}, 0);

        for (int i = 0; i < 5; i++) begin
            display = 1'b0;
            load_image(vecs[i]);
            sb_q.delete();
            push_sb(vecs[i], 1024 + 32);
            run_frame(i == 0, (i == 3) ? 2000 : -1);
        end

        display = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge pixclk);
        #1 reset = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 6000 && !found; i++) begin
            @(negedge pixclk);
            if (pif.row_addr == 3'd3 && !pif.oe_n) found = 1'b1;
        end
        check("reach_show_row3", found, 1);
        reset = 1'b1;
        #1;
        check("reset_oe_n_immediate", pif.oe_n, 1);
        @(posedge pixclk);
        #1 reset = 1'b0;
        @(negedge pixclk);
        check("restart_frame_start", frame_start, 1);
        check("restart_rd_addr", pif.rd_addr, 0);
        check("restart_row_addr", pif.row_addr, 0);
        check("restart_oe_n", pif.oe_n, 1);
        @(negedge pixclk);
        check("restart_rd_bot", pif.rd_addr, 9'h100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
